// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the PWM output path: state encoding, default widths, clock constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

   localparam int DW_DEFAULT = 16;

   // 50 MHz core clock; the upstream PWM counter uses the same constant
   localparam int CLK_PER_US = 50;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_DEAD_TO_H = 3'd1;
   localparam state_t ST_HIGH      = 3'd2;
   localparam state_t ST_DEAD_TO_L = 3'd3;
   localparam state_t ST_LOW       = 3'd4;
   localparam state_t ST_FAULT     = 3'd5;

   function automatic logic is_dead(input state_t s);
      return (s == ST_DEAD_TO_H) || (s == ST_DEAD_TO_L);
   endfunction

endpackage

// File: rtl/pwm_deadtime_if.sv
// Control/status bundle between the PWM controller and the dead-time output stage.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels.
interface pwm_deadtime_if #(parameter int DW = pwm_pkg::DW_DEFAULT);

   logic          en;
   logic          pwm_in;
   logic [DW-1:0] dead_cycles;
   logic          fault;
   logic          fault_clr;
   logic          out_h;
   logic          out_l;
   logic          fault_latched;
   logic          dead_active;

   modport master (
      output en, pwm_in, dead_cycles, fault, fault_clr,
      input  out_h, out_l, fault_latched, dead_active
   );

   modport slave (
      input  en, pwm_in, dead_cycles, fault, fault_clr,
      output out_h, out_l, fault_latched, dead_active
   );

endinterface

// File: rtl/pwm_deadtime_timer.sv
// Dead-time down-counter: loads max(value,1)-1, counts down to zero and holds there.
// Latency: zero flag reflects the registered count, valid the cycle after load.
// Backpressure: none; load has priority over decrement.
module pwm_dead_timer #(
   parameter int DW = pwm_pkg::DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   input  logic [DW-1:0] value,
   output logic          zero
);

   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   logic [DW-1:0] cnt_q, cnt_d;

   // next count: a zero request behaves like one cycle, and decrement stops at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = (value == '0) ? '0 : (value - ONE);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage with programmable dead time and latched fault shutdown.
// Latency: pwm_in -> turn-off in 2 cycles, turn-on after a further D cycles; fault -> outputs low in 1 cycle.
// Backpressure: none; inputs are sampled every cycle.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   pwm_deadtime_if.slave  bus
);

   state_t state_q, state_d;
   logic   pwm_q, pwm_d;
   logic   orig_idle_q, orig_idle_d;   // current dead interval was started from IDLE
   logic   out_h_q, out_h_d;
   logic   out_l_q, out_l_d;
   logic   fault_latched_q, fault_latched_d;
   logic   dead_active_q, dead_active_d;

   logic   tmr_load;
   logic   tmr_dec;
   logic   tmr_zero;

   assign pwm_d    = bus.pwm_in;
   // reload on every entry into a dead state, including a retarget between the two
   assign tmr_load = is_dead(state_d) && (state_d != state_q);
   assign tmr_dec  = is_dead(state_q);

   pwm_dead_timer #(.DW(DW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .dec   (tmr_dec),
      .value (bus.dead_cycles),
      .zero  (tmr_zero)
   );

   // state register plus registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         pwm_q           <= 1'b0;
         orig_idle_q     <= 1'b0;
         out_h_q         <= 1'b0;
         out_l_q         <= 1'b0;
         fault_latched_q <= 1'b0;
         dead_active_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         pwm_q           <= pwm_d;
         orig_idle_q     <= orig_idle_d;
         out_h_q         <= out_h_d;
         out_l_q         <= out_l_d;
         fault_latched_q <= fault_latched_d;
         dead_active_q   <= dead_active_d;
      end
   end

   // next-state: fault beats everything, then fault exit, then enable, then waveform tracking
   always_comb begin
      state_d     = state_q;
      orig_idle_d = orig_idle_q;
      if (bus.fault) begin
         state_d = ST_FAULT;
      end else if (state_q == ST_FAULT) begin
         if (bus.fault_clr) state_d = ST_IDLE;
      end else if (!bus.en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = pwm_q ? ST_DEAD_TO_H : ST_DEAD_TO_L;
               orig_idle_d = 1'b1;
            end
            ST_LOW: begin
               if (pwm_q) begin
                  state_d     = ST_DEAD_TO_H;
                  orig_idle_d = 1'b0;
               end
            end
            ST_HIGH: begin
               if (!pwm_q) begin
                  state_d     = ST_DEAD_TO_L;
                  orig_idle_d = 1'b0;
               end
            end
            ST_DEAD_TO_H: begin
               if (!pwm_q)        state_d = orig_idle_q ? ST_DEAD_TO_L : ST_LOW;
               else if (tmr_zero) state_d = ST_HIGH;
            end
            ST_DEAD_TO_L: begin
               if (pwm_q)         state_d = orig_idle_q ? ST_DEAD_TO_H : ST_HIGH;
               else if (tmr_zero) state_d = ST_LOW;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // outputs decoded from the next state so they switch on the same edge as the state
   always_comb begin
      out_h_d         = (state_d == ST_HIGH);
      out_l_d         = (state_d == ST_LOW);
      fault_latched_d = (state_d == ST_FAULT);
      dead_active_d   = is_dead(state_d);
   end

   assign bus.out_h         = out_h_q;
   assign bus.out_l         = out_l_q;
   assign bus.fault_latched = fault_latched_q;
   assign bus.dead_active   = dead_active_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_deadtime;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   pwm_deadtime_if #(.DW(16)) bus ();

   pwm_deadtime #(.DW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // in = {en, pwm_in, fault, fault_clr}; exp = {out_h, out_l, fault_latched, dead_active}
   typedef struct {
      logic [3:0]  in;
      logic [15:0] dead;
      logic [3:0]  exp;
   } vec_t;

   vec_t vecs[28];

   logic [1:0] wave[160];
   logic [1:0] wave_a[160];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int outs();
      return int'({bus.out_h, bus.out_l, bus.fault_latched, bus.dead_active});
   endfunction

   // advance one clock; outputs are looked at 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
      check("no_overlap", int'(bus.out_h & bus.out_l), 0);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.en          = 1'b0;
      bus.pwm_in      = 1'b0;
      bus.dead_cycles = 16'd0;
      bus.fault       = 1'b0;
      bus.fault_clr   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // bounded wait for the selected output to go high
   task automatic wait_out(input logic want_h, input int limit, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         step();
         seen = want_h ? bus.out_h : bus.out_l;
      end
      check(name, int'(seen), 1);
   endtask

   // count both-low cycles of the next gap; dead_cycles is rewritten once the gap has begun
   task automatic measure_gap(input logic [15:0] new_dead, output int g);
      g = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (!bus.out_h && !bus.out_l) begin
            g++;
            if (g == 1) bus.dead_cycles = new_dead;
         end else if (g > 0) begin
            break;
         end
      end
   endtask

   // 20 high / 20 low square wave; every run after the start-up ones is checked
   task automatic run_square(input logic [15:0] d, input int exp_d);
      logic [1:0] prev;
      int len, run_idx;
      do_reset();
      bus.dead_cycles = d;
      bus.en          = 1'b1;
      for (int c = 0; c < 160; c++) begin
         bus.pwm_in = ((c / 20) % 2 == 1);
         step();
         wave[c] = {bus.out_h, bus.out_l};
      end
      prev    = wave[0];
      len     = 1;
      run_idx = 0;
      for (int c = 1; c < 160; c++) begin
         if (wave[c] == prev) begin
            len++;
         end else begin
            if (run_idx >= 2) begin
               case (prev)
                  2'b10:   check("h_width", len, 20 - exp_d);
                  2'b01:   check("l_width", len, 20 - exp_d);
                  default: check("gap_width", len, exp_d);
               endcase
            end
            run_idx++;
            prev = wave[c];
            len  = 1;
         end
      end
      check("runs_seen", int'(run_idx >= 8), 1);
   endtask

   initial begin
      int g, l_low, da_cnt, h_cnt, diffs;

      vecs[0]  = '{4'b1000, 16'd3, 4'b0001};
      vecs[1]  = '{4'b1000, 16'd3, 4'b0001};
      vecs[2]  = '{4'b1000, 16'd3, 4'b0001};
      vecs[3]  = '{4'b1000, 16'd3, 4'b0100};
      vecs[4]  = '{4'b1100, 16'd3, 4'b0100};
      vecs[5]  = '{4'b1100, 16'd3, 4'b0001};
      vecs[6]  = '{4'b1100, 16'd3, 4'b0001};
      vecs[7]  = '{4'b1100, 16'd3, 4'b0001};
      vecs[8]  = '{4'b1100, 16'd3, 4'b1000};
      vecs[9]  = '{4'b1000, 16'd3, 4'b1000};
      vecs[10] = '{4'b1000, 16'd3, 4'b0001};
      vecs[11] = '{4'b1100, 16'd3, 4'b0001};
      vecs[12] = '{4'b1100, 16'd3, 4'b1000};   // abort back to HIGH
      vecs[13] = '{4'b1110, 16'd3, 4'b0010};   // fault from HIGH
      vecs[14] = '{4'b1111, 16'd3, 4'b0010};   // fault wins over clear
      vecs[15] = '{4'b1001, 16'd3, 4'b0000};   // clear -> IDLE
      vecs[16] = '{4'b1100, 16'd3, 4'b0001};   // IDLE sees old pwm_q=0 -> DEAD_TO_L
      vecs[17] = '{4'b1000, 16'd3, 4'b0001};   // retarget to DEAD_TO_H
      vecs[18] = '{4'b1000, 16'd3, 4'b0001};   // retarget to DEAD_TO_L, reload
      vecs[19] = '{4'b1000, 16'd3, 4'b0001};
      vecs[20] = '{4'b1000, 16'd3, 4'b0001};
      vecs[21] = '{4'b1000, 16'd3, 4'b0100};
      vecs[22] = '{4'b0000, 16'd3, 4'b0000};   // en low -> IDLE
      vecs[23] = '{4'b0010, 16'd3, 4'b0010};   // fault from IDLE
      vecs[24] = '{4'b1000, 16'd3, 4'b0010};   // en ignored in FAULT
      vecs[25] = '{4'b1001, 16'd3, 4'b0000};
      vecs[26] = '{4'b1000, 16'd0, 4'b0001};   // zero dead time acts as one cycle
      vecs[27] = '{4'b1000, 16'd0, 4'b0100};

      do_reset();
      check("reset_outs", outs(), 0);

      for (int i = 0; i < 28; i++) begin
         {bus.en, bus.pwm_in, bus.fault, bus.fault_clr} = vecs[i].in;
         bus.dead_cycles = vecs[i].dead;
         step();
         if (outs() != int'(vecs[i].exp))
            $display("vector %0d in=%b", i, vecs[i].in);
         check("vec_outs", outs(), int'(vecs[i].exp));
      end

      // square waves: D=5, then D=0 and D=1 must produce the same waveform
      run_square(16'd5, 5);
      run_square(16'd0, 1);
      for (int c = 0; c < 160; c++) wave_a[c] = wave[c];
      run_square(16'd1, 1);
      diffs = 0;
      for (int c = 0; c < 160; c++) if (wave[c] != wave_a[c]) diffs++;
      check("d0_vs_d1_diffs", diffs, 0);

      // short high pulse: 4 cycles of pwm_in high against D=10 gives a 4-cycle out_l dip
      // (drop on the edge after pwm_q rises, return on the edge after pwm_q falls)
      do_reset();
      bus.dead_cycles = 16'd10;
      bus.en          = 1'b1;
      wait_out(1'b0, 30, "abort_wait_l");
      l_low = 0; da_cnt = 0; h_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         bus.pwm_in = (i < 4);
         step();
         if (!bus.out_l)      l_low++;
         if (bus.dead_active) da_cnt++;
         if (bus.out_h)       h_cnt++;
      end
      check("abort_l_low", l_low, 4);
      check("abort_dead_active", da_cnt, 4);
      check("abort_h_on", h_cnt, 0);
      check("abort_l_back", int'(bus.out_l), 1);

      // fault while out_h is on, clear, then a full dead time before turn-on
      do_reset();
      bus.dead_cycles = 16'd5;
      bus.en          = 1'b1;
      bus.pwm_in      = 1'b1;
      wait_out(1'b1, 30, "fault_wait_h");
      bus.fault = 1'b1;
      step();
      check("fault_outs", outs(), 4'b0010);
      bus.fault_clr = 1'b1;
      step();
      check("fault_clr_held", outs(), 4'b0010);
      bus.fault = 1'b0;
      step();
      check("fault_cleared", outs(), 0);
      bus.fault_clr = 1'b0;
      measure_gap(16'd5, g);
      check("post_fault_gap", g, 5);
      check("post_fault_h", int'(bus.out_h), 1);

      // enable dropped in the middle of a dead interval
      do_reset();
      bus.dead_cycles = 16'd5;
      bus.en          = 1'b1;
      step();
      step();
      check("en_drop_pre_dead", int'(bus.dead_active), 1);
      bus.en = 1'b0;
      step();
      check("en_drop_outs", outs(), 0);

      // dead_cycles changed mid-gap: this gap keeps 5, the next one uses 50
      do_reset();
      bus.dead_cycles = 16'd5;
      bus.en          = 1'b1;
      wait_out(1'b0, 30, "dchg_wait_l");
      bus.pwm_in = 1'b1;
      measure_gap(16'd50, g);
      check("dchg_gap_cur", g, 5);
      check("dchg_h_on", int'(bus.out_h), 1);
      step();
      step();
      bus.pwm_in = 1'b0;
      measure_gap(16'd50, g);
      check("dchg_gap_next", g, 50);
      check("dchg_l_on", int'(bus.out_l), 1);

      // asynchronous reset between edges while out_l is on, then while faulted
      do_reset();
      bus.dead_cycles = 16'd2;
      bus.en          = 1'b1;
      wait_out(1'b0, 30, "arst_wait_l");
      #5 rst = 1'b1;
      #2;
      check("arst_outs_low", outs(), 0);
      @(negedge clk);
      rst       = 1'b0;
      bus.fault = 1'b1;
      step();
      check("arst_fault_set", int'(bus.fault_latched), 1);
      #5 rst = 1'b1;
      #2;
      check("arst_fault_drop", outs(), 0);
      @(negedge clk);
      rst       = 1'b0;
      bus.fault = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
